// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   ctrl_state_e  : controller FSM states
//   FWD_*         : forward-mux select encodings driven on fwd_a / fwd_b
//   hazard_ctrl_t : bundle of stall / flush / bubble strobes, plus the
//                   fixed patterns the controller drives in each situation
package Pipe_Buf_Reg_PKG;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    MULTI  = 2'b01,
    DRAIN  = 2'b10,
    HALTED = 2'b11
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_bubble;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_NONE     = 5'b00000;
  localparam hazard_ctrl_t CTRL_RESET    = 5'b00111;
  localparam hazard_ctrl_t CTRL_LOAD_USE = 5'b11010;
  localparam hazard_ctrl_t CTRL_BRANCH   = 5'b00110;
  localparam hazard_ctrl_t CTRL_MULTI    = 5'b11001;
  localparam hazard_ctrl_t CTRL_HALT_ACC = 5'b00010;
  // Front end frozen and ID/EX emptied, used while draining and halted.
  localparam hazard_ctrl_t CTRL_HOLD     = 5'b11010;

endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// Forward-mux select for one EX operand.
//   ex_rs                      : source register of the ID/EX instruction
//   mem_rd / mem_regwrite      : destination and write enable at MEM
//   wb_rd  / wb_regwrite       : destination and write enable at WB
//   fwd                        : FWD_MEM, FWD_WB or FWD_RF
// MEM holds the younger result, so it wins over WB. Register 0 is never
// forwarded because it is hard-wired to zero in the register file.
module fwd_sel
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int RF_ADDRESS = 5
) (
  input  logic [RF_ADDRESS-1:0] ex_rs,
  input  logic [RF_ADDRESS-1:0] mem_rd,
  input  logic [RF_ADDRESS-1:0] wb_rd,
  input  logic                  mem_regwrite,
  input  logic                  wb_regwrite,
  output logic [1:0]            fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (mem_regwrite && (mem_rd == ex_rs) && (mem_rd != '0)) begin
      fwd = FWD_MEM;
    end else if (wb_regwrite && (wb_rd == ex_rs) && (wb_rd != '0)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard / stall controller for a 5-stage pipeline.
//   clk, reset (async, active-low)
//   id_rs1/2, ex_rs1/2, ex_rd, mem_rd, wb_rd : register numbers per stage
//   ex_memread, mem_regwrite, wb_regwrite    : stage control bits
//   branch_taken, ex_busy, halt_req, resume  : events from the datapath
//   pc_stall, ifid_stall                     : hold PC and IF/ID
//   ifid_flush, idex_flush, exmem_bubble     : squash stage control
//   fwd_a, fwd_b                             : forward-mux selects
//   halted, tmo_err, stall_cnt               : status
module pipe_ctrl
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int RF_ADDRESS = 5,
  parameter int DRAIN_CYC  = 3,
  parameter int MULTI_TMO  = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic [RF_ADDRESS-1:0] ex_rs1,
  input  logic [RF_ADDRESS-1:0] ex_rs2,
  input  logic [RF_ADDRESS-1:0] ex_rd,
  input  logic [RF_ADDRESS-1:0] mem_rd,
  input  logic [RF_ADDRESS-1:0] wb_rd,
  input  logic                  ex_memread,
  input  logic                  mem_regwrite,
  input  logic                  wb_regwrite,
  input  logic                  branch_taken,
  input  logic                  ex_busy,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  halted,
  output logic                  tmo_err,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int BUSY_W  = $clog2(MULTI_TMO + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);
  localparam logic [BUSY_W-1:0]  BUSY_LAST  = BUSY_W'(MULTI_TMO - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);

  ctrl_state_e         state_q, state_d;
  logic [BUSY_W-1:0]   busy_cnt_q, busy_cnt_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic                tmo_err_q, tmo_err_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  hazard_ctrl_t        ctrl;
  logic                halted_c;
  logic                load_use;
  logic [1:0]          fwd_a_raw, fwd_b_raw;

  fwd_sel #(.RF_ADDRESS(RF_ADDRESS)) u_fwd_a (
    .ex_rs        (ex_rs1),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .mem_regwrite (mem_regwrite),
    .wb_regwrite  (wb_regwrite),
    .fwd          (fwd_a_raw)
  );

  fwd_sel #(.RF_ADDRESS(RF_ADDRESS)) u_fwd_b (
    .ex_rs        (ex_rs2),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .mem_regwrite (mem_regwrite),
    .wb_regwrite  (wb_regwrite),
    .fwd          (fwd_b_raw)
  );

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      busy_cnt_q  <= '0;
      drain_cnt_q <= '0;
      tmo_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_cnt_q  <= busy_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      tmo_err_q   <= tmo_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Priority in RUN: an unfinished EX op outranks everything (its branch
  // outcome is not valid yet), then branch, then load-use. A halt is only
  // accepted when none of these apply; a squashed or stalled halt is
  // re-presented by ID later.
  always_comb begin
    state_d     = state_q;
    busy_cnt_d  = busy_cnt_q;
    drain_cnt_d = drain_cnt_q;
    tmo_err_d   = tmo_err_q;
    case (state_q)
      RUN: begin
        busy_cnt_d = '0;
        if (ex_busy) begin
          state_d = MULTI;
        end else if (halt_req && !branch_taken && !load_use) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      MULTI: begin
        if (!ex_busy) begin
          state_d    = RUN;
          busy_cnt_d = '0;
        end else if (busy_cnt_q == BUSY_LAST) begin
          // Watchdog: give up on the EX unit and let the pipe move again.
          state_d    = RUN;
          busy_cnt_d = '0;
          tmo_err_d  = 1'b1;
        end else begin
          busy_cnt_d = busy_cnt_q + BUSY_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
      end
      HALTED: begin
        if (resume) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Reset overrides the strobes combinationally so downstream stages see
  // flush/bubble the moment reset asserts, not one edge later.
  always_comb begin
    ctrl     = CTRL_NONE;
    halted_c = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_busy)           ctrl = CTRL_MULTI;
        else if (branch_taken) ctrl = CTRL_BRANCH;
        else if (load_use)     ctrl = CTRL_LOAD_USE;
        else if (halt_req)     ctrl = CTRL_HALT_ACC;
      end
      MULTI: begin
        if (ex_busy)           ctrl = CTRL_MULTI;
        else if (branch_taken) ctrl = CTRL_BRANCH;
      end
      DRAIN: ctrl = CTRL_HOLD;
      HALTED: begin
        ctrl     = CTRL_HOLD;
        halted_c = 1'b1;
      end
      default: ctrl = CTRL_NONE;
    endcase
    if (!reset) begin
      ctrl     = CTRL_RESET;
      halted_c = 1'b0;
    end
  end

  // A parked pipeline is not a hazard stall, so HALTED is not counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl.pc_stall && (state_q != HALTED) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign ifid_stall   = ctrl.ifid_stall;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_bubble = ctrl.exmem_bubble;
  assign fwd_a        = reset ? fwd_a_raw : FWD_RF;
  assign fwd_b        = reset ? fwd_b_raw : FWD_RF;
  assign halted       = halted_c;
  assign tmo_err      = tmo_err_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for single-cycle hazard and
// forwarding behaviour, plus hand-written multi-cycle sequences for MULTI,
// timeout, drain/halt, reset aborts and stall counter saturation.
module tb_pipe_ctrl;

  localparam int RFA  = 5;
  localparam int DCYC = 3;
  localparam int TMO  = 8;
  localparam int CW   = 16;

  // Strobe order {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_bubble}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_RESET = 5'b00111;
  localparam logic [4:0] C_LU    = 5'b11010;
  localparam logic [4:0] C_BR    = 5'b00110;
  localparam logic [4:0] C_MUL   = 5'b11001;
  localparam logic [4:0] C_HACC  = 5'b00010;
  localparam logic [4:0] C_HOLD  = 5'b11010;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [RFA-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic ex_memread, mem_regwrite, wb_regwrite, branch_taken, ex_busy;
  logic halt_req, resume;
  logic pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic halted, tmo_err;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad = 0;
  int exp_stall = 0;

  typedef struct {
    string      name;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_memread, mem_regwrite, wb_regwrite, branch_taken, halt_req;
    logic [4:0] exp_ctrl;
    logic [1:0] exp_fwd_a, exp_fwd_b;
  } vec_t;

  vec_t vecs[$];

  pipe_ctrl #(
    .RF_ADDRESS (RFA),
    .DRAIN_CYC  (DCYC),
    .MULTI_TMO  (TMO),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .ex_memread   (ex_memread),
    .mem_regwrite (mem_regwrite),
    .wb_regwrite  (wb_regwrite),
    .branch_taken (branch_taken),
    .ex_busy      (ex_busy),
    .halt_req     (halt_req),
    .resume       (resume),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_bubble (exmem_bubble),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .halted       (halted),
    .tmo_err      (tmo_err),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk_vec(input string n,
      input logic [4:0] i1, input logic [4:0] i2,
      input logic [4:0] e1, input logic [4:0] e2,
      input logic [4:0] erd, input logic [4:0] mrd, input logic [4:0] wrd,
      input logic mr, input logic mrw, input logic wrw,
      input logic br, input logic hr,
      input logic [4:0] ec, input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.name = n;
    v.id_rs1 = i1; v.id_rs2 = i2; v.ex_rs1 = e1; v.ex_rs2 = e2;
    v.ex_rd = erd; v.mem_rd = mrd; v.wb_rd = wrd;
    v.ex_memread = mr; v.mem_regwrite = mrw; v.wb_regwrite = wrw;
    v.branch_taken = br; v.halt_req = hr;
    v.exp_ctrl = ec; v.exp_fwd_a = fa; v.exp_fwd_b = fb;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_memread = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    branch_taken = 1'b0; ex_busy = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic set_load_use();
    id_rs2 = 5'd5; ex_rd = 5'd5; ex_memread = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2;
    ex_rd = v.ex_rd; mem_rd = v.mem_rd; wb_rd = v.wb_rd;
    ex_memread = v.ex_memread; mem_regwrite = v.mem_regwrite;
    wb_regwrite = v.wb_regwrite; branch_taken = v.branch_taken;
    halt_req = v.halt_req; ex_busy = 1'b0; resume = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_ctrl(input string name, input logic [4:0] exp_ctrl,
                            input logic exp_halted);
    checkOutput({name, ".ctrl"},
                32'({pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_bubble}),
                32'(exp_ctrl));
    checkOutput({name, ".halted"}, 32'(halted), 32'(exp_halted));
  endtask

  task automatic run_cycle(input string name, input logic [4:0] exp_ctrl,
                           input logic exp_halted);
    @(negedge clk);
    check_ctrl(name, exp_ctrl, exp_halted);
    next_cycle();
  endtask

  task automatic check_reset(input string name);
    check_ctrl(name, C_RESET, 1'b0);
    checkOutput({name, ".fwdA"}, 32'(fwd_a), 32'd0);
    checkOutput({name, ".fwdB"}, 32'(fwd_b), 32'd0);
    checkOutput({name, ".stallCnt"}, 32'(stall_cnt), 32'd0);
    checkOutput({name, ".tmoErr"}, 32'(tmo_err), 32'd0);
  endtask

  initial begin
    //                 name          id1 id2 ex1 ex2 exrd mrd wrd  mr mrw wrw br ht  ctrl    fa     fb
    vecs.push_back(mk_vec("idle",       0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00));
    vecs.push_back(mk_vec("fwdMem",     0, 0, 3, 4, 0, 3, 3, 0, 1, 1, 0, 0, C_NONE, 2'b10, 2'b00));
    vecs.push_back(mk_vec("fwdWb",      0, 0, 3, 4, 0, 3, 3, 0, 0, 1, 0, 0, C_NONE, 2'b01, 2'b00));
    vecs.push_back(mk_vec("fwdZero",    0, 0, 0, 4, 0, 0, 0, 0, 1, 1, 0, 0, C_NONE, 2'b00, 2'b00));
    vecs.push_back(mk_vec("fwdMix",     0, 0, 9, 7, 0, 7, 9, 0, 1, 1, 0, 0, C_NONE, 2'b01, 2'b10));
    vecs.push_back(mk_vec("fwdNoMatch", 0, 0, 8, 8, 0, 7, 9, 0, 1, 1, 0, 0, C_NONE, 2'b00, 2'b00));
    vecs.push_back(mk_vec("loadUseRs2", 1, 5, 1, 2, 5, 0, 0, 1, 0, 0, 0, 0, C_LU,   2'b00, 2'b00));
    vecs.push_back(mk_vec("loadUseRs1", 6, 2, 1, 2, 6, 0, 0, 1, 0, 0, 0, 0, C_LU,   2'b00, 2'b00));
    vecs.push_back(mk_vec("loadRdZero", 0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00));
    vecs.push_back(mk_vec("loadNoUse",  4, 7, 1, 2, 5, 0, 0, 1, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00));
    vecs.push_back(mk_vec("branch",     0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, C_BR,   2'b00, 2'b00));
    vecs.push_back(mk_vec("branchLoad", 5, 0, 1, 2, 5, 0, 0, 1, 0, 0, 1, 0, C_BR,   2'b00, 2'b00));
    vecs.push_back(mk_vec("branchHalt", 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1, C_BR,   2'b00, 2'b00));
    vecs.push_back(mk_vec("afterBrHalt",0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00));
    vecs.push_back(mk_vec("loadHalt",   5, 0, 1, 2, 5, 0, 0, 1, 0, 0, 0, 1, C_LU,   2'b00, 2'b00));
    vecs.push_back(mk_vec("afterLdHalt",0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00));

    // Reset values hold even with forwarding and busy inputs active.
    clear_inputs();
    reset = 1'b0;
    repeat (2) next_cycle();
    mem_regwrite = 1'b1; mem_rd = 5'd3; ex_rs1 = 5'd3; ex_busy = 1'b1;
    @(negedge clk);
    check_reset("inReset");
    next_cycle();
    reset = 1'b1;
    clear_inputs();
    run_cycle("postReset", C_NONE, 1'b0);

    // Single load-use stall, then released.
    set_load_use();
    run_cycle("loadUse", C_LU, 1'b0);
    exp_stall++;
    clear_inputs();
    @(negedge clk);
    check_ctrl("loadUseAfter", C_NONE, 1'b0);
    checkOutput("loadUseCnt", 32'(stall_cnt), 32'(exp_stall));
    next_cycle();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      check_ctrl(vecs[i].name, vecs[i].exp_ctrl, 1'b0);
      checkOutput({vecs[i].name, ".fwdA"}, 32'(fwd_a), 32'(vecs[i].exp_fwd_a));
      checkOutput({vecs[i].name, ".fwdB"}, 32'(fwd_b), 32'(vecs[i].exp_fwd_b));
      if (vecs[i].exp_ctrl[4]) exp_stall++;
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    checkOutput("tableStallCnt", 32'(stall_cnt), 32'(exp_stall));
    next_cycle();

    // Four busy cycles, release, then a load-use proves the FSM is in RUN.
    ex_busy = 1'b1;
    for (int k = 0; k < 4; k++) run_cycle("multiBusy", C_MUL, 1'b0);
    exp_stall += 4;
    ex_busy = 1'b0;
    run_cycle("multiExit", C_NONE, 1'b0);
    set_load_use();
    run_cycle("multiBackRun", C_LU, 1'b0);
    exp_stall++;
    clear_inputs();
    @(negedge clk);
    checkOutput("multiStallCnt", 32'(stall_cnt), 32'(exp_stall));
    next_cycle();

    // Branch ignored while busy, honoured on the exit cycle.
    ex_busy = 1'b1;
    run_cycle("multiBr0", C_MUL, 1'b0);
    branch_taken = 1'b1;
    run_cycle("multiBrBusy", C_MUL, 1'b0);
    ex_busy = 1'b0;
    run_cycle("multiBrExit", C_BR, 1'b0);
    exp_stall += 2;
    clear_inputs();
    run_cycle("multiBrIdle", C_NONE, 1'b0);

    // Stuck EX unit: one RUN cycle plus TMO MULTI cycles, then forced RUN.
    ex_busy = 1'b1;
    for (int k = 0; k <= TMO; k++) begin
      @(negedge clk);
      check_ctrl("tmoBusy", C_MUL, 1'b0);
      checkOutput("tmoNotYet", 32'(tmo_err), 32'd0);
      next_cycle();
    end
    exp_stall += TMO + 1;
    ex_busy = 1'b0;
    set_load_use();
    @(negedge clk);
    check_ctrl("tmoForcedRun", C_LU, 1'b0);
    checkOutput("tmoSet", 32'(tmo_err), 32'd1);
    next_cycle();
    exp_stall++;
    clear_inputs();
    @(negedge clk);
    checkOutput("tmoStallCnt", 32'(stall_cnt), 32'(exp_stall));
    next_cycle();

    // Halt: accept, three drain cycles (resume ignored), halted, resume.
    halt_req = 1'b1;
    run_cycle("haltAccept", C_HACC, 1'b0);
    halt_req = 1'b0;
    run_cycle("drain1", C_HOLD, 1'b0);
    resume = 1'b1;
    run_cycle("drain2", C_HOLD, 1'b0);
    resume = 1'b0;
    run_cycle("drain3", C_HOLD, 1'b0);
    exp_stall += DCYC;
    run_cycle("halted1", C_HOLD, 1'b1);
    run_cycle("halted2", C_HOLD, 1'b1);
    resume = 1'b1;
    @(negedge clk);
    check_ctrl("haltedResume", C_HOLD, 1'b1);
    checkOutput("haltStallCnt", 32'(stall_cnt), 32'(exp_stall));
    checkOutput("tmoSticky", 32'(tmo_err), 32'd1);
    next_cycle();
    resume = 1'b0;
    run_cycle("resumedRun", C_NONE, 1'b0);

    // Reset asserted in the middle of MULTI.
    ex_busy = 1'b1;
    next_cycle();
    #2;
    reset = 1'b0;
    #1;
    check_reset("rstMulti");
    @(posedge clk);
    #1;
    clear_inputs();
    reset = 1'b1;
    set_load_use();
    @(negedge clk);
    check_ctrl("rstMultiRun", C_LU, 1'b0);
    checkOutput("rstMultiCnt", 32'(stall_cnt), 32'd0);
    next_cycle();
    clear_inputs();

    // Reset asserted in the middle of DRAIN; no halt may follow.
    halt_req = 1'b1;
    next_cycle();
    halt_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_reset("rstDrain");
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) run_cycle("rstDrainIdle", C_NONE, 1'b0);

    // Saturation: every cycle stalls for 70000 edges.
    ex_busy = 1'b1;
    for (int k = 1; k <= 70000; k++) begin
      @(posedge clk);
      if (k == 65534) begin
        @(negedge clk);
        checkOutput("stallCntNearSat", 32'(stall_cnt), 32'd65534);
      end
    end
    @(negedge clk);
    checkOutput("stallCntSat", 32'(stall_cnt), 32'd65535);
    checkOutput("satStillStall", 32'(pc_stall), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
